// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - request/result bundle between the ALU select logic and the multiplier
interface shift_add_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - radix-2 shift-and-add unsigned multiplier with its accumulate adder
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c_in);
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave sif
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_c;
  logic                 step_c;
  logic [WIDTH-1:0]     step_hi;
  logic [2*WIDTH:0]     acc_step;
  logic                 carry_slot_unused;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  // The top slot only ever holds a carry for one combinational step; after the shift it is always zero.
  assign carry_slot_unused = acc_q[2*WIDTH];

  adder #(.WIDTH(WIDTH)) u_adder (
    .a     (acc_hi),
    .b     (mcand_q),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_c)
  );

  always_comb begin
    step_c   = acc_q[0] ? add_c   : 1'b0;
    step_hi  = acc_q[0] ? add_sum : acc_hi;
    acc_step = {step_c, step_hi, acc_q[WIDTH-1:0]} >> 1;

    state_d   = state_q;
    counter_d = counter_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sif.start == 1'b1) begin
          state_d   = ST_RUN;
          mcand_d   = sif.multiplicand;
          acc_d     = {1'b0, {WIDTH{1'b0}}, sif.multiplier};
          counter_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d     = acc_step;
        counter_d = counter_q + 1'b1;
        if (counter_q == CNT_W'(WIDTH-1)) begin
          state_d   = ST_DONE;
          product_d = acc_step[2*WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sif.busy    = busy_q;
  assign sif.done    = done_q;
  assign sif.product = product_q;

  a_start_known_idle: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == ST_IDLE) |-> !$isunknown(sif.start)
  );
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(32)) mif ();

  shift_add_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (mif.slave)
  );

  // Caller sits at a negedge; the following posedge accepts the request.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    mif.start        = 1'b1;
    mif.multiplicand = a;
    mif.multiplier   = b;
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  // Edges counted from the accept edge (1) to the edge that raises done; -1 on timeout.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 1;
    busy_cnt = 0;
    while (mif.done !== 1'b1 && edges < 60) begin
      if (mif.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    if (mif.done !== 1'b1) edges = -1;
  endtask

  task automatic test_reset();
    int e, b;
    rst_n            = 1'b0;
    mif.start        = 1'b0;
    mif.multiplicand = '0;
    mif.multiplier   = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.product !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b product=%h expected 0/0/0", mif.busy, mif.done, mif.product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_op(32'd3, 32'd3);
    wait_done(e, b);
    tests_run++;
    if (mif.product !== 64'd9) begin
      tests_failed++;
      $display("FAIL reset_pre_product: got %h expected %h", mif.product, 64'd9);
    end
    @(negedge clk);
    start_op(32'd3, 32'd3);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.product !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_async: busy=%b done=%b product=%h expected 0/0/0", mif.busy, mif.done, mif.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e, b;
    start_op(32'd5, 32'd6);
    wait_done(e, b);
    tests_run++;
    if (e !== 33) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected 33", e);
    end
    tests_run++;
    if (b !== 32) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d expected 32", b);
    end
    tests_run++;
    if (mif.product !== 64'd30) begin
      tests_failed++;
      $display("FAIL basic_5x6: got %h expected %h", mif.product, 64'd30);
    end
    @(negedge clk);
    tests_run++;
    if (mif.done !== 1'b0 || mif.busy !== 1'b0 || mif.product !== 64'd30) begin
      tests_failed++;
      $display("FAIL basic_after_done: done=%b busy=%b product=%h expected 0/0/1e", mif.done, mif.busy, mif.product);
    end
    start_op(32'd4, 32'd5);
    wait_done(e, b);
    tests_run++;
    if (mif.product !== 64'd20) begin
      tests_failed++;
      $display("FAIL basic_4x5: got %h expected %h", mif.product, 64'd20);
    end
    @(negedge clk);
  endtask

  task automatic test_corners();
    int e, b;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, b);
    tests_run++;
    if (mif.product !== 64'hFFFF_FFFE_0000_0001) begin
      tests_failed++;
      $display("FAIL corner_max: got %h expected %h", mif.product, 64'hFFFF_FFFE_0000_0001);
    end
    @(negedge clk);
    start_op(32'd0, 32'h1234_5678);
    wait_done(e, b);
    tests_run++;
    if (mif.product !== 64'd0) begin
      tests_failed++;
      $display("FAIL corner_zero: got %h expected %h", mif.product, 64'd0);
    end
    tests_run++;
    if (e !== 33) begin
      tests_failed++;
      $display("FAIL corner_zero_latency: got %0d expected 33", e);
    end
    @(negedge clk);
    start_op(32'd1, 32'h8000_0000);
    wait_done(e, b);
    tests_run++;
    if (mif.product !== 64'h0000_0000_8000_0000) begin
      tests_failed++;
      $display("FAIL corner_msb: got %h expected %h", mif.product, 64'h0000_0000_8000_0000);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int first_done = -1;
    logic [63:0] seen = '0;
    int edges;
    start_op(32'd10, 32'd6);
    edges = 1;
    repeat (9) begin
      @(negedge clk);
      edges++;
    end
    start_op(32'd3, 32'd3);
    edges++;
    for (int i = 0; i < 40; i++) begin
      if (mif.done === 1'b1) begin
        pulses++;
        if (first_done < 0) begin
          first_done = edges;
          seen = mif.product;
        end
      end
      @(negedge clk);
      edges++;
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL ignore_pulses: got %0d expected 1", pulses);
    end
    tests_run++;
    if (seen !== 64'd60) begin
      tests_failed++;
      $display("FAIL ignore_product: got %h expected %h", seen, 64'd60);
    end
    tests_run++;
    if (first_done !== 33) begin
      tests_failed++;
      $display("FAIL ignore_latency: got %0d expected 33", first_done);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int e, b;
    start_op(32'd7, 32'd9);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: busy=%b done=%b expected 0/0", mif.busy, mif.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (mif.done === 1'b1) pulses++;
      @(negedge clk);
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d pulses expected 0", pulses);
    end
    start_op(32'd7, 32'd9);
    wait_done(e, b);
    tests_run++;
    if (e !== 33 || mif.product !== 64'd63) begin
      tests_failed++;
      $display("FAIL midreset_restart: latency=%0d product=%h expected 33/%h", e, mif.product, 64'd63);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int e, b;
    int bad_hold = 0;
    start_op(32'd4, 32'd5);
    wait_done(e, b);
    tests_run++;
    if (mif.product !== 64'd20) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h expected %h", mif.product, 64'd20);
    end
    start_op(32'd2, 32'd3);
    e = 1;
    while (mif.done !== 1'b1 && e < 60) begin
      if (mif.product !== 64'd20) bad_hold++;
      @(negedge clk);
      e++;
    end
    tests_run++;
    if (bad_hold !== 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got %0d cycles with product!=20 expected 0", bad_hold);
    end
    tests_run++;
    if (mif.done !== 1'b1 || e !== 33) begin
      tests_failed++;
      $display("FAIL b2b_latency: done=%b edges=%0d expected 1/33", mif.done, e);
    end
    tests_run++;
    if (mif.product !== 64'd6) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h expected %h", mif.product, 64'd6);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
